// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider.
// Contents: FSM state encodings (IDLE, CALC, FIX) and the default
// divisor/quotient width.
package div_pkg;

    localparam int DIV_W = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

endpackage : div_pkg

// File: rtl/div_step.sv
// One combinational restoring-division step.
// Ports:
//   pr_in    [W:0]   partial remainder entering this step
//   bit_in           next dividend bit, MSB first
//   dvs_mag  [W-1:0] divisor magnitude
//   pr_out   [W:0]   partial remainder after shift / trial-subtract / restore
//   q_bit            quotient bit produced by this step
module div_step #(
    parameter int W = 8
) (
    input  logic [W:0]   pr_in,
    input  logic         bit_in,
    input  logic [W-1:0] dvs_mag,
    output logic [W:0]   pr_out,
    output logic         q_bit
);

    logic [W:0]   shifted;
    logic [W+1:0] diff;
    // The partial remainder stays below |dvs| <= 2**(W-1) whenever the
    // result is used, so its top bit never carries information into the shift.
    logic         unused_pr_msb;

    assign unused_pr_msb = pr_in[W];
    assign shifted       = {pr_in[W-1:0], bit_in};
    assign diff          = {1'b0, shifted} - {2'b00, dvs_mag};
    assign q_bit         = ~diff[W+1];
    assign pr_out        = q_bit ? diff[W:0] : shifted;

endmodule : div_step

// File: rtl/seq_divider_16x8.sv
// Multi-cycle signed divider: 2W-bit dividend / W-bit divisor giving a
// W-bit quotient (truncated toward zero) and W-bit remainder (sign of the
// dividend). Fixed latency of W+1 cycles after the start edge, including
// divide-by-zero and overflow cases.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         load operands (only honoured in IDLE)
//   dvd [2W-1:0]  signed dividend
//   dvs [W-1:0]   signed divisor
//   busy          operation in progress
//   done          one-cycle pulse when quo/rem/ovf/dvz update
//   quo, rem      signed results, held until the next done
//   ovf           quotient not representable in W bits
//   dvz           divisor was zero
//
// state | meaning
// IDLE  | waiting for start; operands and flags latched on start
// CALC  | W restoring steps, one per cycle
// FIX   | sign fix-up, error forcing, result registration, done pulse
module seq_divider_16x8
    import div_pkg::*;
#(
    parameter int W     = DIV_W,
    parameter int CNT_W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*W-1:0] dvd,
    input  logic [W-1:0]   dvs,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   quo,
    output logic [W-1:0]   rem,
    output logic           ovf,
    output logic           dvz
);

    localparam logic [W-1:0]     QMAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]     QMAX_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [W:0]       pr;
    logic [W-1:0]     q_sr;
    logic [W-1:0]     dvs_mag;
    logic             sign_q;
    logic             sign_r;
    logic             hi_ovf;
    logic             zero_dvs;

    // Magnitudes carry one extra bit so the most negative inputs negate exactly.
    logic [2*W:0] dvd_ext;
    logic [2*W:0] dvd_abs;
    logic [W:0]   dvs_ext;
    logic [W:0]   dvs_abs;
    logic         hi_ovf_in;

    assign dvd_ext   = {dvd[2*W-1], dvd};
    assign dvd_abs   = dvd[2*W-1] ? (~dvd_ext + 1'b1) : dvd_ext;
    assign dvs_ext   = {dvs[W-1], dvs};
    assign dvs_abs   = dvs[W-1] ? (~dvs_ext + 1'b1) : dvs_ext;
    // Upper half >= divisor means the unsigned quotient needs more than W bits.
    assign hi_ovf_in = (dvd_abs[2*W:W] >= dvs_abs);

    logic [W:0] pr_nxt;
    logic       q_bit;

    div_step #(.W(W)) u_step (
        .pr_in   (pr),
        .bit_in  (q_sr[W-1]),
        .dvs_mag (dvs_mag),
        .pr_out  (pr_nxt),
        .q_bit   (q_bit)
    );

    // Result fix-up, evaluated in FIX. q_sr holds the unsigned quotient and
    // pr the unsigned remainder once the W steps have run.
    logic [W-1:0] q_signed;
    logic [W-1:0] r_signed;
    logic         ovf_res;

    assign q_signed = sign_q ? (~q_sr + 1'b1) : q_sr;
    assign r_signed = sign_r ? (~pr[W-1:0] + 1'b1) : pr[W-1:0];
    assign ovf_res  = hi_ovf
                    | (~sign_q & (q_sr > QMAX_POS))
                    | ( sign_q & (q_sr > QMAX_NEG));

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            pr       <= '0;
            q_sr     <= '0;
            dvs_mag  <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            hi_ovf   <= 1'b0;
            zero_dvs <= 1'b0;
            done     <= 1'b0;
            quo      <= '0;
            rem      <= '0;
            ovf      <= 1'b0;
            dvz      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Upper dividend half seeds the partial remainder; the
                        // lower half is shifted out MSB first while quotient
                        // bits are shifted in behind it.
                        pr       <= {1'b0, dvd_abs[2*W-1:W]};
                        q_sr     <= dvd_abs[W-1:0];
                        dvs_mag  <= dvs_abs[W-1:0];
                        sign_q   <= dvd[2*W-1] ^ dvs[W-1];
                        sign_r   <= dvd[2*W-1];
                        hi_ovf   <= hi_ovf_in;
                        zero_dvs <= (dvs == '0);
                        cnt      <= '0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    pr   <= pr_nxt;
                    q_sr <= {q_sr[W-2:0], q_bit};
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    done  <= 1'b1;
                    dvz   <= zero_dvs;
                    ovf   <= ~zero_dvs & ovf_res;
                    if (zero_dvs || ovf_res) begin
                        quo <= '0;
                        rem <= '0;
                    end else begin
                        quo <= q_signed;
                        rem <= r_signed;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : seq_divider_16x8

// File: tb/tb_seq_divider_16x8.sv
module tb_seq_divider_16x8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dvd = '0;
    logic [7:0]  dvs = '0;
    logic        busy, done, ovf, dvz;
    logic [7:0]  quo, rem;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_divider_16x8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .dvd   (dvd),
        .dvs   (dvs),
        .busy  (busy),
        .done  (done),
        .quo   (quo),
        .rem   (rem),
        .ovf   (ovf),
        .dvz   (dvz)
    );

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        o;
        logic        z;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain signed integer division (truncating), range check.
    task automatic model(input logic [15:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic o, output logic z);
        int ai, bi, qi, ri;
        ai = int'($signed(a));
        bi = int'($signed(b));
        q = '0; r = '0; o = 1'b0; z = 1'b0;
        if (bi == 0) begin
            z = 1'b1;
        end else begin
            qi = ai / bi;
            ri = ai % bi;
            if (qi > 127 || qi < -128) o = 1'b1;
            else begin
                q = 8'(qi);
                r = 8'(ri);
            end
        end
    endtask

    // Pulse start for one cycle; lat = edges from the start edge to done.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b, output int lat);
        @(negedge clk);
        dvd = a; dvs = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        while (lat < 30) begin
            @(posedge clk);
            #1 lat++;
            if (done) break;
        end
    endtask

    task automatic check_result(input string nm, input logic [15:0] a, input logic [7:0] b,
                                input logic [7:0] q, input logic [7:0] r,
                                input logic o, input logic z, input int lat);
        chk({nm, " lat"}, lat, 9);
        chk({nm, " busy"}, busy, 1'b0);
        chk({nm, " quo"}, quo, q);
        chk({nm, " rem"}, rem, r);
        chk({nm, " ovf"}, ovf, o);
        chk({nm, " dvz"}, dvz, z);
    endtask

    initial begin
        vec_t vt[$];
        int lat, cnt;
        logic [7:0] eq, er;
        logic eo, ez;
        logic [15:0] ra;
        logic [7:0] rb;

        vt.push_back('{16'h000F, 8'h04, 8'h03, 8'h03, 1'b0, 1'b0});
        vt.push_back('{16'hFF9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0});
        vt.push_back('{16'hFD44, 8'hF9, 8'h64, 8'h00, 1'b0, 1'b0});
        vt.push_back('{16'h1234, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1});
        vt.push_back('{16'h4000, 8'h02, 8'h00, 8'h00, 1'b1, 1'b0});
        vt.push_back('{16'h0080, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0});
        vt.push_back('{16'hFF80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0});
        vt.push_back('{16'h8000, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0});
        vt.push_back('{16'h007F, 8'h01, 8'h7F, 8'h00, 1'b0, 1'b0});
        vt.push_back('{16'hFF7F, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0});
        vt.push_back('{16'h3F80, 8'h80, 8'h81, 8'h00, 1'b0, 1'b0});
        vt.push_back('{16'h4000, 8'h80, 8'h80, 8'h00, 1'b0, 1'b0});
        vt.push_back('{16'hC000, 8'h80, 8'h00, 8'h00, 1'b1, 1'b0});
        vt.push_back('{16'h7FFF, 8'h80, 8'h00, 8'h00, 1'b1, 1'b0});
        vt.push_back('{16'h0005, 8'hFD, 8'hFF, 8'h02, 1'b0, 1'b0});

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset quo", quo, 8'h00);
        chk("reset rem", rem, 8'h00);
        chk("reset ovf", ovf, 1'b0);
        chk("reset dvz", dvz, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < vt.size(); i++) begin
            run_op(vt[i].a, vt[i].b, lat);
            check_result($sformatf("vec%0d", i), vt[i].a, vt[i].b,
                         vt[i].q, vt[i].r, vt[i].o, vt[i].z, lat);
            @(posedge clk);
            #1 chk($sformatf("vec%0d done pulse", i), done, 1'b0);
        end

        // Randomized against the reference model
        for (int i = 0; i < 300; i++) begin
            rb = 8'($urandom);
            case ($urandom_range(0, 2))
                0: ra = 16'($urandom);
                1: ra = 16'(int'($signed(8'($urandom))) * int'($signed(rb))
                            + int'($urandom_range(0, 6)) - 3);
                default: ra = 16'(int'($urandom_range(0, 2000)) - 1000);
            endcase
            if ($urandom_range(0, 19) == 0) rb = 8'h00;
            model(ra, rb, eq, er, eo, ez);
            run_op(ra, rb, lat);
            check_result($sformatf("rnd %h/%h", ra, rb), ra, rb, eq, er, eo, ez, lat);
        end

        // start re-pulsed in CALC cycle 3 with other operands: ignored
        @(negedge clk);
        dvd = 16'h000F; dvs = 8'h04; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dvd = 16'h0100; dvs = 8'h03;
        lat = 0;
        while (lat < 30) begin
            @(posedge clk);
            #1 lat++;
            start = (lat == 2);
            if (done) break;
        end
        start = 1'b0;
        check_result("repulse", 16'h000F, 8'h04, 8'h03, 8'h03, 1'b0, 1'b0, lat);
        @(posedge clk);
        #1 chk("repulse no restart", busy, 1'b0);

        // start held through FIX: not taken there, taken in the following IDLE
        @(negedge clk);
        dvd = 16'hFF9C; dvs = 8'h07; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        while (lat < 30) begin
            @(posedge clk);
            #1 lat++;
            if (lat == 8) begin
                dvd = 16'h0064; dvs = 8'h05; start = 1'b1;
            end
            if (done) break;
        end
        check_result("fix start first", 16'hFF9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0, lat);
        @(posedge clk);
        #1 start = 1'b0;
        cnt = 1;
        while (cnt < 30) begin
            @(posedge clk);
            #1 cnt++;
            if (done) break;
        end
        chk("fix start gap", cnt, 10);
        chk("fix start quo", quo, 8'h14);
        chk("fix start rem", rem, 8'h00);

        // Reset mid-CALC aborts; next op completes normally
        @(negedge clk);
        dvd = 16'hFF9C; dvs = 8'h07; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort busy", busy, 1'b0);
        chk("abort done", done, 1'b0);
        chk("abort quo", quo, 8'h00);
        chk("abort rem", rem, 8'h00);
        chk("abort ovf", ovf, 1'b0);
        chk("abort dvz", dvz, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1 if (done || busy) cnt++;
        end
        chk("abort no done", cnt, 0);
        run_op(16'hFD44, 8'hF9, lat);
        check_result("after abort", 16'hFD44, 8'hF9, 8'h64, 8'h00, 1'b0, 1'b0, lat);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_seq_divider_16x8
